// File: rtl/tick_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_sched_pkg
// Description : Shared types and helpers for the tick scheduler.
//               cfg_state_t  - configuration FSM state encoding
//               clamp_period - maps a zero period onto one
// Revision    : 1.0 - initial release
// ============================================================================
package tick_sched_pkg;

    typedef enum logic [0:0] {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_t;

    // A zero period would make the terminal count underflow; treat it as 1.
    function automatic logic [31:0] clamp_period(input logic [31:0] period);
        return (period == 32'd0) ? 32'd1 : period;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ============================================================================
// Module      : tick_channel
// Description : One programmable tick channel driven by the shared base tick.
//               Ports: clk_in, reset (sync, active high), base_tick (enable),
//               load/load_period/load_en (one-cycle reconfiguration),
//               tick_out (one-cycle pulse), clk_out (50% divided clock).
// Revision    : 1.0 - initial release
// ============================================================================
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int PW             = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          base_tick,
    input  logic          load,
    input  logic [PW-1:0] load_period,
    input  logic          load_en,
    output logic          tick_out,
    output logic          clk_out
);

    localparam logic [PW-1:0] c_DEFAULT = PW'(clamp_period(32'(DEFAULT_PERIOD)));

    logic          r_en;
    logic [PW-1:0] r_period;
    logic [PW-1:0] r_cnt;
    logic          r_tick;
    logic          r_clk;
    logic          w_last;

    // period is never 0, so period-1 cannot wrap.
    assign w_last = (r_cnt == (r_period - PW'(1)));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_period <= c_DEFAULT;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_clk    <= 1'b0;
        end else if (load) begin
            // A load takes priority over a coincident terminal count.
            r_en     <= load_en;
            r_period <= PW'(clamp_period(32'(load_period)));
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_clk    <= 1'b0;
        end else if (!r_en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (base_tick) begin
                if (w_last) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    r_clk  <= ~r_clk;
                end else begin
                    r_cnt <= r_cnt + PW'(1);
                end
            end
        end
    end

    assign tick_out = r_tick;
    assign clk_out  = r_clk;

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Shared prescaler feeding N_CH programmable tick channels.
//               Ports: clk_in, reset (sync, active high),
//               cfg_valid/cfg_ready/cfg_ch/cfg_period/cfg_en (config port),
//               base_tick (prescaler pulse), tick_out[N_CH], clk_out[N_CH].
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int N_CH           = 3,
    parameter int PRESCALE       = 100,
    parameter int PW             = 16,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [PW-1:0]   cfg_period,
    input  logic            cfg_en,
    output logic            base_tick,
    output logic [N_CH-1:0] tick_out,
    output logic [N_CH-1:0] clk_out
);

    localparam int c_PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [c_PRE_W-1:0] r_pre_cnt;
    logic               r_base_tick;
    cfg_state_t         r_state;
    logic               r_cfg_ready;
    logic [CH_W-1:0]    r_cfg_ch;
    logic [PW-1:0]      r_cfg_period;
    logic               r_cfg_en;
    logic [N_CH-1:0]    w_load;

    // Free-running prescaler; configuration never touches it.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_pre_cnt   <= '0;
            r_base_tick <= 1'b0;
        end else begin
            r_base_tick <= (r_pre_cnt == c_PRE_W'(PRESCALE - 1));
            if (r_pre_cnt == c_PRE_W'(PRESCALE - 1)) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
            end
        end
    end

    // Configuration FSM: accept in IDLE, apply for exactly one cycle.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= CFG_IDLE;
            r_cfg_ready  <= 1'b1;
            r_cfg_ch     <= '0;
            r_cfg_period <= '0;
            r_cfg_en     <= 1'b0;
        end else begin
            case (r_state)
                CFG_IDLE: begin
                    if (cfg_valid) begin
                        r_cfg_ch     <= cfg_ch;
                        r_cfg_period <= cfg_period;
                        r_cfg_en     <= cfg_en;
                        r_state      <= CFG_APPLY;
                        r_cfg_ready  <= 1'b0;
                    end
                end
                CFG_APPLY: begin
                    r_state     <= CFG_IDLE;
                    r_cfg_ready <= 1'b1;
                end
                default: begin
                    r_state     <= CFG_IDLE;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    // An out-of-range channel index matches no channel, so the APPLY is a no-op.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_load[i] = (r_state == CFG_APPLY) && (r_cfg_ch == CH_W'(i));

        tick_channel #(
            .PW            (PW),
            .DEFAULT_PERIOD(DEFAULT_PERIOD)
        ) u_channel (
            .clk_in     (clk_in),
            .reset      (reset),
            .base_tick  (r_base_tick),
            .load       (w_load[i]),
            .load_period(r_cfg_period),
            .load_en    (r_cfg_en),
            .tick_out   (tick_out[i]),
            .clk_out    (clk_out[i])
        );
    end

    assign base_tick = r_base_tick;
    assign cfg_ready = r_cfg_ready;

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Self-checking bench for tick_scheduler (PRESCALE=4, N_CH=3,
//               PW=8, DEFAULT_PERIOD=2). Reference model counts base ticks
//               consumed since each channel's last configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int c_PRE  = 4;
    localparam int c_NCH  = 3;
    localparam int c_PW   = 8;

    logic             clk_in = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_ch = '0;
    logic [c_PW-1:0]  cfg_period = '0;
    logic             cfg_en = 1'b0;
    logic             base_tick;
    logic [c_NCH-1:0] tick_out;
    logic [c_NCH-1:0] clk_out;

    tick_scheduler #(
        .N_CH          (c_NCH),
        .PRESCALE      (c_PRE),
        .PW            (c_PW),
        .DEFAULT_PERIOD(2)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_en    (cfg_en),
        .base_tick (base_tick),
        .tick_out  (tick_out),
        .clk_out   (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  n;                 // clock edges since the last reset edge
    bit  m_bt;              // expected base_tick after the current edge
    bit  m_pending;         // a configuration has been accepted, APPLY next edge
    int  m_lch, m_lper;
    bit  m_len;
    bit  m_en [c_NCH];
    int  m_per[c_NCH];
    int  m_bc [c_NCH];      // base ticks consumed since last configuration
    logic [c_NCH-1:0] exp_tick, exp_clk;
    logic exp_ready;

    task automatic check_outputs();
        checks++;
        assert (base_tick === m_bt) else begin
            errors++;
            $error("FAIL base_tick n=%0d observed=%b expected=%b", n, base_tick, m_bt);
        end
        checks++;
        assert (cfg_ready === exp_ready) else begin
            errors++;
            $error("FAIL cfg_ready n=%0d observed=%b expected=%b", n, cfg_ready, exp_ready);
        end
        checks++;
        assert (tick_out === exp_tick) else begin
            errors++;
            $error("FAIL tick_out n=%0d observed=%b expected=%b", n, tick_out, exp_tick);
        end
        checks++;
        assert (clk_out === exp_clk) else begin
            errors++;
            $error("FAIL clk_out n=%0d observed=%b expected=%b", n, clk_out, exp_clk);
        end
    endtask

    // Advance one clock, update the model from the inputs sampled on that edge,
    // then compare one time unit after the edge.
    task automatic step();
        bit applied[c_NCH];
        bit bt_prev;
        @(posedge clk_in);
        if (reset) begin
            n = 0;
            m_bt = 1'b0;
            m_pending = 1'b0;
            for (int i = 0; i < c_NCH; i++) begin
                m_en[i] = 1'b0;
                m_per[i] = 2;
                m_bc[i] = 0;
            end
            exp_tick = '0;
            exp_clk = '0;
        end else begin
            bt_prev = m_bt;
            for (int i = 0; i < c_NCH; i++) applied[i] = 1'b0;
            if (m_pending) begin
                m_pending = 1'b0;
                if (m_lch < c_NCH) begin
                    m_en[m_lch]  = m_len;
                    m_per[m_lch] = (m_lper == 0) ? 1 : m_lper;
                    m_bc[m_lch]  = 0;
                    applied[m_lch] = 1'b1;
                end
            end else if (cfg_valid) begin
                m_pending = 1'b1;
                m_lch  = int'(cfg_ch);
                m_lper = int'(cfg_period);
                m_len  = cfg_en;
            end
            for (int i = 0; i < c_NCH; i++) begin
                if (!applied[i] && m_en[i] && bt_prev) m_bc[i]++;
                exp_tick[i] = !applied[i] && m_en[i] && bt_prev && (m_bc[i] % m_per[i] == 0);
                exp_clk[i]  = m_en[i] && (((m_bc[i] / m_per[i]) % 2) == 1);
            end
            n++;
            m_bt = (n % c_PRE == 0);
        end
        exp_ready = !m_pending;
        #1;
        check_outputs();
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic cfg(input int ch, input int per, input bit en);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = c_PW'(per);
        cfg_en     = en;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        bit found;

        // 1. reset for two cycles, then release
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(12);

        // 2. ch0 period 3
        cfg(0, 3, 1'b1);
        run(50);

        // 3. ch1 period 1 and ch2 period 5 back-to-back
        cfg(1, 1, 1'b1);
        cfg(2, 5, 1'b1);
        run(60);

        // 4. period 0 behaves as 1; out-of-range channel is a no-op
        cfg(2, 0, 1'b1);
        run(20);
        cfg(3, 6, 1'b0);
        run(20);

        // 5. APPLY on ch0 terminal count
        cfg(0, 2, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            if ((n % c_PRE == 3) && (m_bc[0] % 2 == 1)) found = 1'b1;
            else step();
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL tc_align observed=%b expected=%b", found, 1'b1);
        end
        cfg(0, 2, 1'b1);
        run(24);
        cfg(0, 2, 1'b0);
        run(30);

        // 6. reset while in APPLY with channels running
        cfg(0, 3, 1'b1);
        run(10);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd7; cfg_en = 1'b0;
        step();
        cfg_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(20);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = c_PW'($urandom_range(0, 6));
            cfg_en     = ($urandom_range(0, 4) != 0);
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        cfg_valid = 1'b0;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
